// File: rtl/phase_acc_if.sv
// -----------------------------------------------------------------------------
// phase_acc_if
//   Bundles the frequency-word handshake, the oscillator sync input and the
//   ramp-address output stream of the phase accumulator.
//
//   Signals (names as seen from the accumulator):
//     i_freq_word   ACC_W   phase increment offered by the control front end
//     i_freq_valid  1       frequency word offered
//     o_freq_ready  1       accumulator can accept a frequency word
//     i_sync        1       hard phase reset (oscillator sync), level
//     o_addr        ADDR_W  ramp address to the waveform block
//     o_addr_valid  1       one-cycle strobe, o_addr updated this cycle
//     o_wrap        1       one-cycle strobe on accumulator carry-out
//
//   Modports:
//     slave   - the phase accumulator itself
//     master  - the surrounding system (front end + waveform consumer)
// -----------------------------------------------------------------------------
interface phase_acc_if #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 16
);
  logic [ACC_W-1:0]  i_freq_word;
  logic              i_freq_valid;
  logic              o_freq_ready;
  logic              i_sync;
  logic [ADDR_W-1:0] o_addr;
  logic              o_addr_valid;
  logic              o_wrap;

  modport slave (
    input  i_freq_word,
    input  i_freq_valid,
    input  i_sync,
    output o_freq_ready,
    output o_addr,
    output o_addr_valid,
    output o_wrap
  );

  modport master (
    output i_freq_word,
    output i_freq_valid,
    output i_sync,
    input  o_freq_ready,
    input  o_addr,
    input  o_addr_valid,
    input  o_wrap
  );
endinterface

// File: rtl/phase_acc.sv
// -----------------------------------------------------------------------------
// phase_acc
//   Sample-rate phase accumulator (NCO). Once every DIV system clocks the
//   accumulator advances by the active frequency word; the top ADDR_W bits are
//   presented as a ramp address with a one-cycle valid strobe, and a wrap
//   strobe flags the accumulator carry-out.
//
//   Ports:
//     i_clk   system clock, all logic on posedge
//     i_rst   synchronous reset, active-high
//     bus     phase_acc_if.slave: frequency handshake, sync, address stream
//
//   Parameters:
//     ACC_W   accumulator width
//     ADDR_W  output address width (top bits of the accumulator)
//     DIV     system clocks per sample tick (>= 2)
// -----------------------------------------------------------------------------
module phase_acc #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 16,
  parameter int DIV    = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  phase_acc_if.slave      bus
);

  localparam int CNT_W = $clog2(DIV);

  typedef enum logic {
    IDLE = 1'b0,   // no word pending, ready to accept
    PEND = 1'b1    // word held until the next sample tick
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  div_cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  freq_reg_q;
  logic [ACC_W-1:0]  pending_q;
  state_t            state_q;
  logic              ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_valid_q;
  logic              wrap_q;

  // ---------------------------------------------------------------------------
  // Next-state datapath
  // ---------------------------------------------------------------------------
  logic              tick;
  logic              advance;
  logic [ACC_W-1:0]  eff_word;
  logic [CNT_W-1:0]  div_cnt_d;
  logic [ACC_W-1:0]  acc_d;
  logic              carry_d;

  // NOTE: every signal assigned in always_comb gets a default on entry so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tick      = 1'b0;
    advance   = 1'b0;
    eff_word  = freq_reg_q;
    div_cnt_d = div_cnt_q + CNT_W'(1);
    acc_d     = acc_q;
    carry_d   = 1'b0;

    tick = (div_cnt_q == CNT_W'(DIV - 1));
    if (tick) begin
      div_cnt_d = '0;
    end

    // Sync overrides a coincident tick: no add, no strobe, no word transfer.
    advance = tick && !bus.i_sync;

    // A pending word takes effect on the very tick that transfers it.
    if (state_q == PEND) begin
      eff_word = pending_q;
    end

    {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, eff_word};
  end

  // ---------------------------------------------------------------------------
  // Accumulator, tick divider and registered address outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_cnt_q    <= '0;
      acc_q        <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else if (bus.i_sync) begin
      // Restarting the divider makes the first post-sync tick land DIV
      // clocks after sync is released.
      div_cnt_q    <= '0;
      acc_q        <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      if (tick) begin
        acc_q        <= acc_d;
        addr_q       <= acc_d[ACC_W-1 -: ADDR_W];
        addr_valid_q <= 1'b1;
        wrap_q       <= carry_d;
      end else begin
        addr_valid_q <= 1'b0;
        wrap_q       <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frequency-word handshake FSM
  //   ready_q is registered: it stays low for the first cycle after reset and
  //   rises the cycle after a pending word is consumed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      pending_q  <= '0;
      freq_reg_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_freq_valid && ready_q) begin
            // A word captured on a tick edge is only used from the next tick,
            // since this tick's add already read freq_reg_q.
            pending_q <= bus.i_freq_word;
            state_q   <= PEND;
            ready_q   <= 1'b0;
          end else begin
            ready_q   <= 1'b1;
          end
        end
        PEND: begin
          // Offers are ignored here; the held word is never overwritten.
          if (advance) begin
            freq_reg_q <= pending_q;
            state_q    <= IDLE;
            ready_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_freq_ready = ready_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_addr_valid = addr_valid_q;
  assign bus.o_wrap       = wrap_q;

endmodule

// File: tb/tb_phase_acc.sv
// -----------------------------------------------------------------------------
// tb_phase_acc
//   Directed bench for phase_acc with DIV=4. A cycle-by-cycle vector table
//   covers reset and the first frequency load; hand-written sequences cover
//   wrap-around, half-scale stepping, handshake back-pressure, capture on a
//   tick, sync (pulsed and held) and reset with a word pending.
// -----------------------------------------------------------------------------
module tb_phase_acc;

  localparam int ACC_W  = 32;
  localparam int ADDR_W = 16;
  localparam int DIV    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  phase_acc_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

  phase_acc #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIV(DIV)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] word;
    logic        sync;
    logic        exp_ready;
    logic [15:0] exp_addr;
    logic        exp_av;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] w, input logic s);
    rst              = r;
    bus.i_freq_valid = v;
    bus.i_freq_word  = w;
    bus.i_sync       = s;
    @(posedge clk);
    #1;
  endtask

  // Idle until the next address strobe; n = cycles taken.
  task automatic wait_strobe(input string name, input int limit, output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end while (!bus.o_addr_valid && n < limit);
    check({name, "_strobe_seen"}, 64'(bus.o_addr_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.i_freq_valid = 1'b0;
    bus.i_freq_word  = '0;
    bus.i_sync       = 1'b0;

    //           rst  vld  word           sync rdy  addr      av   wrap
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h0100, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h0200, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h0200, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].word, vecs[i].sync);
      check($sformatf("vec%0d_ready", i), 64'(bus.o_freq_ready), 64'(vecs[i].exp_ready));
      check($sformatf("vec%0d_addr", i),  64'(bus.o_addr),       64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_valid", i), 64'(bus.o_addr_valid), 64'(vecs[i].exp_av));
      check($sformatf("vec%0d_wrap", i),  64'(bus.o_wrap),       64'(vecs[i].exp_wrap));
    end

    // Step 0x0100 per strobe up to the 256th strobe, which wraps to 0.
    for (int k = 3; k <= 256; k++) begin
      wait_strobe($sformatf("ramp%0d", k), 8, n);
      if (k > 3) check($sformatf("ramp%0d_spacing", k), 64'(n), 64'(DIV));
      check($sformatf("ramp%0d_addr", k), 64'(bus.o_addr), 64'((k * 256) % 65536));
      check($sformatf("ramp%0d_wrap", k), 64'(bus.o_wrap), 64'(k == 256));
    end

    // Half-scale word: 0x8000, 0x0000 (wrap), ...
    step(1'b0, 1'b1, 32'h8000_0000, 1'b0);
    check("half_ready_low", 64'(bus.o_freq_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      wait_strobe($sformatf("half%0d", i), 8, n);
      check($sformatf("half%0d_addr", i), 64'(bus.o_addr), (i % 2 == 0) ? 64'h8000 : 64'h0);
      check($sformatf("half%0d_wrap", i), 64'(bus.o_wrap), 64'(i % 2));
    end

    // Back-to-back offers: the second is not accepted.
    step(1'b0, 1'b1, 32'h0001_0000, 1'b0);
    check("b2b_ready_after_first", 64'(bus.o_freq_ready), 64'd0);
    step(1'b0, 1'b1, 32'h0002_0000, 1'b0);
    check("b2b_ready_after_second", 64'(bus.o_freq_ready), 64'd0);
    wait_strobe("b2b_a", 8, n);
    check("b2b_a_addr", 64'(bus.o_addr), 64'h0001);
    check("b2b_a_ready", 64'(bus.o_freq_ready), 64'd1);
    step(1'b0, 1'b1, 32'h0002_0000, 1'b0);
    check("b2b_reoffer_taken", 64'(bus.o_freq_ready), 64'd0);
    wait_strobe("b2b_b", 8, n);
    check("b2b_b_addr", 64'(bus.o_addr), 64'h0003);
    wait_strobe("b2b_c", 8, n);
    check("b2b_c_addr", 64'(bus.o_addr), 64'h0005);

    // Word captured on the tick edge is used only from the next tick.
    for (int i = 0; i < DIV - 1; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0010_0000, 1'b0);
    check("tickcap_valid", 64'(bus.o_addr_valid), 64'd1);
    check("tickcap_addr_old_word", 64'(bus.o_addr), 64'h0007);
    check("tickcap_ready", 64'(bus.o_freq_ready), 64'd0);
    wait_strobe("tickcap_next", 8, n);
    check("tickcap_next_addr", 64'(bus.o_addr), 64'h0017);

    // Sync pulse coincident with a tick.
    step(1'b0, 1'b1, 32'h0100_0000, 1'b0);
    wait_strobe("sync_pre", 8, n);
    check("sync_pre_addr", 64'(bus.o_addr), 64'h0117);
    for (int i = 0; i < DIV - 1; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("sync_no_strobe", 64'(bus.o_addr_valid), 64'd0);
    check("sync_addr_zero", 64'(bus.o_addr), 64'h0);
    check("sync_no_wrap", 64'(bus.o_wrap), 64'd0);
    wait_strobe("sync_post", 8, n);
    check("sync_post_spacing", 64'(n), 64'(DIV));
    check("sync_post_addr", 64'(bus.o_addr), 64'h0100);

    // Sync held high: frozen at 0, no strobes.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check($sformatf("hold%0d_valid", i), 64'(bus.o_addr_valid), 64'd0);
      check($sformatf("hold%0d_addr", i), 64'(bus.o_addr), 64'h0);
    end
    wait_strobe("hold_release", 8, n);
    check("hold_release_spacing", 64'(n), 64'(DIV));
    check("hold_release_addr", 64'(bus.o_addr), 64'h0100);

    // Reset while a word is pending: word and freq_reg discarded.
    step(1'b0, 1'b1, 32'h0400_0000, 1'b0);
    check("rstpend_ready_low", 64'(bus.o_freq_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check($sformatf("rstpend%0d_ready", i), 64'(bus.o_freq_ready), 64'd0);
      check($sformatf("rstpend%0d_addr", i), 64'(bus.o_addr), 64'h0);
      check($sformatf("rstpend%0d_valid", i), 64'(bus.o_addr_valid), 64'd0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("rstpend_ready_after", 64'(bus.o_freq_ready), 64'd1);
    wait_strobe("rstpend_a", 8, n);
    check("rstpend_a_spacing", 64'(n), 64'(DIV - 1));
    check("rstpend_a_addr", 64'(bus.o_addr), 64'h0);
    check("rstpend_a_wrap", 64'(bus.o_wrap), 64'd0);
    wait_strobe("rstpend_b", 8, n);
    check("rstpend_b_spacing", 64'(n), 64'(DIV));
    check("rstpend_b_addr", 64'(bus.o_addr), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
